encoder_scan_sched: RTL and testbench
=====================================

Name: encoder_scan_sched

Overview:
- Shares one period-measurement counter across N_CH quadrature/index encoder inputs.
- Selects channels round-robin and measures each selected channel for one full rising-edge-to-rising-edge period, with a timeout.
- Stores each result into a per-channel register bank.
- Sits between the raw encoder pins and the speed/control logic, which reads stable per-channel periods and stall flags.

Parameters:
- N_CH, 4, number of encoder channels scanned
- WIDTH, 32, width of each stored period and of the shared counter
- TIMEOUT, 1000, cycles allowed in ARM or MEASURE before the channel is declared stalled; must satisfy TIMEOUT < 2**WIDTH

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- enable  in  1  scan enable; low aborts the current measurement
- encoder  in  N_CH  raw asynchronous encoder inputs
- period_flat  out  N_CH*WIDTH  last period per channel; channel c is at bits [c*WIDTH +: WIDTH]
- valid  out  N_CH  channel holds a completed, non-stalled measurement
- stall  out  N_CH  last attempt on channel timed out
- cur_ch  out  $clog2(N_CH) (min 1)  channel currently selected
- sweep_done  out  1  one-cycle pulse when the last channel (N_CH-1) finishes an attempt

Behaviour:
- Reset (rst_n low at a clk edge):
  - State to IDLE, cur_ch=0, counter=0.
  - All period_flat, valid, stall, sweep_done cleared to 0.
  - Synchronizer flops cleared to 0.
- Input conditioning:
  - Each encoder bit passes through a 2-FF synchronizer, then a prev register.
  - rise[c] = sync[c] & ~prev[c]. This gives a fixed 3-cycle pin-to-pulse latency, identical on all channels.
- FSM states: IDLE, ARM, MEASURE, STORE.
  - IDLE: when enable=1, go to ARM next cycle and clear the counter.
  - ARM: wait for rise[cur_ch].
    - On rise: go to MEASURE, counter=1.
    - Else counter increments; when counter reaches TIMEOUT, go to STORE with the stall outcome.
  - MEASURE: counter increments each cycle.
    - On rise[cur_ch]: latch period = counter value at that cycle (cycles between the two detected edges), then go to STORE with the ok outcome.
    - When counter reaches TIMEOUT before a rise: go to STORE with the stall outcome.
  - STORE (1 cycle):
    - ok outcome: period_flat[cur_ch] = period, valid[cur_ch]=1, stall[cur_ch]=0.
    - stall outcome: period_flat[cur_ch]=0, valid[cur_ch]=0, stall[cur_ch]=1.
    - sweep_done=1 if cur_ch==N_CH-1.
    - cur_ch wraps (N_CH-1)->0, else increments.
    - Next state is ARM if enable=1, else IDLE.
- Period arithmetic:
  - Example: pin high 1 cycle, low 2 cycles, repeating, gives period=3.
  - Counter never exceeds TIMEOUT, so there is no overflow.
- The edge that ends MEASURE is not reused. The next channel re-arms on its own next rising edge.
- enable=0 during ARM/MEASURE: return to IDLE next cycle; the channel's stored results are unchanged; cur_ch is kept (resume on the same channel).
- rise on a non-selected channel is ignored.
- rise in the same cycle the counter reaches TIMEOUT: the rise wins (ok outcome, period=TIMEOUT).
- Register bank outputs change only in STORE; they are stable otherwise.
- N_CH=1: cur_ch is constantly 0 and sweep_done pulses on every STORE.

Decomposition:
- Package encoder_pkg:
  - state enum (IDLE, ARM, MEASURE, STORE)
  - outcome enum (OK, STALL)
  - localparam helper for the channel-index width (max(1,$clog2(N_CH))).
- Sub-module encoder_edge_sync (2-FF sync + prev + rise pulse, synchronous active-low reset), instantiated N_CH times via generate.
- The scheduler FSM, shared counter and register bank stay in encoder_scan_sched.

Test Plan:
1. Reset check: hold rst_n=0 for 3 clk (10-unit clock) with toggling encoders -> all outputs 0, cur_ch=0.
2. Single channel, steady signal: N_CH=4, enable=1, ch0 high 10/low 20 repeating, other channels toggling with a 40-unit period -> period_flat[ch0]=3, valid[0]=1; ch1..3 report 4.
3. Stall: ch2 held low, TIMEOUT=50 -> stall[2]=1, valid[2]=0, period 0; sweep_done pulses exactly once per pass of ch3.
4. Stall recovery: restart ch2 toggling with a 100-unit period -> next sweep gives period_flat[ch2]=10, stall[2]=0, valid[2]=1.
5. Abort mid-measurement: drop enable during MEASURE on ch1 -> IDLE within 1 cycle, ch1 registers unchanged, cur_ch stays 1; re-enable -> ch1 re-measured with the correct value.
6. Boundary: rise on the exact cycle the counter hits TIMEOUT -> ok outcome, period=TIMEOUT. Also check wrap from ch3 back to ch0 and that reset asserted mid-MEASURE clears everything on the next edge.

Source files
------------

// File: rtl/encoder_pkg.sv
// Shared types and helpers for the encoder period scan scheduler.
package encoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2,
    ST_STORE   = 2'd3
  } state_t;

  typedef enum logic {
    OC_OK    = 1'b0,
    OC_STALL = 1'b1
  } outcome_t;

  // Channel-index width, never narrower than one bit.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/encoder_edge_sync.sv
// Two-flop synchronizer plus previous-value register; emits a one-cycle
// pulse on each rising edge of the synchronized encoder input.
module encoder_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic encoder,
  output logic rise
);

  logic [1:0] sync_r;
  logic       prev_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_r <= 2'b00;
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[0], encoder};
      prev_r <= sync_r[1];
    end
  end

  assign rise = sync_r[1] & ~prev_r;

endmodule

// File: rtl/encoder_scan_sched.sv
// Round-robin period measurement over N_CH encoder inputs using one shared
// counter; results land in a per-channel bank of period/valid/stall registers.
module encoder_scan_sched
  import encoder_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 1000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic [N_CH-1:0]              encoder,
  output logic [N_CH*WIDTH-1:0]        period_flat,
  output logic [N_CH-1:0]              valid,
  output logic [N_CH-1:0]              stall,
  output logic [ch_width(N_CH)-1:0]    cur_ch,
  output logic                         sweep_done
);

  localparam int                CW   = ch_width(N_CH);
  localparam logic [WIDTH-1:0]  TMO  = WIDTH'(TIMEOUT);
  localparam logic [CW-1:0]     LAST = CW'(N_CH - 1);

  state_t                        state_r, state_s;
  outcome_t                      outcome_r, outcome_s;
  logic [WIDTH-1:0]              cnt_r, cnt_s;
  logic [WIDTH-1:0]              meas_r, meas_s;
  logic [CW-1:0]                 cur_r;
  logic [N_CH-1:0][WIDTH-1:0]    period_r;
  logic [N_CH-1:0]               valid_r;
  logic [N_CH-1:0]               stall_r;
  logic                          sweep_r;
  logic [N_CH-1:0]               rise_s;
  logic                          rise_sel_s;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    encoder_edge_sync u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .encoder (encoder[c]),
      .rise    (rise_s[c])
    );
    assign period_flat[c*WIDTH +: WIDTH] = period_r[c];
  end

  assign rise_sel_s = rise_s[cur_r];

  // Next-state logic; a rise always beats a timeout landing on the same cycle.
  always_comb begin
    state_s   = state_r;
    outcome_s = outcome_r;
    cnt_s     = cnt_r;
    meas_s    = meas_r;
    case (state_r)
      ST_IDLE: begin
        if (enable) begin
          state_s = ST_ARM;
          cnt_s   = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ARM: begin
        if (!enable) begin
          state_s = ST_IDLE;
        end else if (rise_sel_s) begin
          state_s = ST_MEASURE;
          cnt_s   = WIDTH'(1);
        end else if (cnt_r == TMO) begin
          state_s   = ST_STORE;
          outcome_s = OC_STALL;
          meas_s    = '0;
        end else begin
          cnt_s = cnt_r + WIDTH'(1);
        end
      end
      ST_MEASURE: begin
        if (!enable) begin
          state_s = ST_IDLE;
        end else if (rise_sel_s) begin
          state_s   = ST_STORE;
          outcome_s = OC_OK;
          meas_s    = cnt_r;
        end else if (cnt_r == TMO) begin
          state_s   = ST_STORE;
          outcome_s = OC_STALL;
          meas_s    = '0;
        end else begin
          cnt_s = cnt_r + WIDTH'(1);
        end
      end
      ST_STORE: begin
        cnt_s = '0;
        if (enable) begin
          state_s = ST_ARM;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      outcome_r <= OC_OK;
      cnt_r     <= '0;
      meas_r    <= '0;
    end else begin
      state_r   <= state_s;
      outcome_r <= outcome_s;
      cnt_r     <= cnt_s;
      meas_r    <= meas_s;
    end
  end

  // Result bank and channel pointer move only when a STORE retires.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      period_r <= '0;
      valid_r  <= '0;
      stall_r  <= '0;
      cur_r    <= '0;
      sweep_r  <= 1'b0;
    end else if (state_r == ST_STORE) begin
      period_r[cur_r] <= meas_r;
      valid_r[cur_r]  <= (outcome_r == OC_OK);
      stall_r[cur_r]  <= (outcome_r == OC_STALL);
      sweep_r         <= (cur_r == LAST);
      cur_r           <= (cur_r == LAST) ? '0 : cur_r + CW'(1);
    end else begin
      sweep_r <= 1'b0;
    end
  end

  assign valid      = valid_r;
  assign stall      = stall_r;
  assign cur_ch     = cur_r;
  assign sweep_done = sweep_r;

endmodule

// File: tb/tb_encoder_scan_sched.sv
// Scoreboard bench: each phase pushes the stores it expects, a monitor pops
// one entry per completed channel attempt and compares the bank outputs.
module tb_encoder_scan_sched;

  localparam int N_CH    = 4;
  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 50;
  localparam int CW      = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  enable;
  logic [N_CH-1:0]       encoder;
  logic [N_CH*WIDTH-1:0] period_flat;
  logic [N_CH-1:0]       valid;
  logic [N_CH-1:0]       stall;
  logic [CW-1:0]         cur_ch;
  logic                  sweep_done;

  encoder_scan_sched #(.N_CH(N_CH), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .encoder     (encoder),
    .period_flat (period_flat),
    .valid       (valid),
    .stall       (stall),
    .cur_ch      (cur_ch),
    .sweep_done  (sweep_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  typedef struct {
    int ch;
    int period;
    bit ok;
    bit sweep;
  } exp_t;

  exp_t q[$];

  // Pin waveform: period in clk cycles (0 = held low), high-time in cycles.
  int per[N_CH] = '{3, 4, 4, 4};
  int hi[N_CH]  = '{1, 2, 2, 2};
  int gcnt;

  int exp_period[N_CH] = '{0, 0, 0, 0};
  bit exp_valid[N_CH]  = '{0, 0, 0, 0};
  bit exp_stall[N_CH]  = '{0, 0, 0, 0};

  initial begin
    gcnt    = 0;
    encoder = '0;
    forever begin
      @(negedge clk);
      gcnt++;
      for (int c = 0; c < N_CH; c++)
        encoder[c] = (per[c] != 0) && ((gcnt % per[c]) < hi[c]);
    end
  end

  // Monitor: a change of cur_ch marks a completed attempt on the previous channel.
  initial begin
    logic [CW-1:0] prev_cur;
    exp_t e;
    int idx;
    prev_cur = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        prev_cur = cur_ch;
      end else if (cur_ch != prev_cur) begin
        idx = prev_cur;
        if (q.size() == 0) begin
          check_val("store_unexpected", 64'(idx), 64'(99));
        end else begin
          e = q.pop_front();
          check_val("store_ch", 64'(idx), 64'(e.ch));
          check_val("period", 64'(period_flat[idx*WIDTH +: WIDTH]), 64'(e.ok ? e.period : 0));
          check_val("valid", 64'(valid[idx]), 64'(e.ok));
          check_val("stall", 64'(stall[idx]), 64'(!e.ok));
          check_val("sweep_done", 64'(sweep_done), 64'(e.sweep));
          check_val("cur_ch_next", 64'(cur_ch), 64'((e.ch + 1) % N_CH));
          exp_period[e.ch] = e.ok ? e.period : 0;
          exp_valid[e.ch]  = e.ok;
          exp_stall[e.ch]  = !e.ok;
        end
        prev_cur = cur_ch;
      end else if (sweep_done) begin
        check_val("sweep_spurious", 64'(sweep_done), 64'(0));
      end
    end
  end

  task automatic push(input int ch, input int period, input bit ok);
    exp_t e;
    e.ch     = ch;
    e.period = period;
    e.ok     = ok;
    e.sweep  = (ch == N_CH - 1);
    q.push_back(e);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 3000 && q.size() != 0; i++) @(negedge clk);
    check_val({"drain_", tag}, 64'(q.size()), 64'(0));
    q.delete();
  endtask

  task automatic wait_ch(input int ch);
    for (int i = 0; i < 1000 && cur_ch != CW'(ch); i++) @(negedge clk);
    check_val("reach_ch", 64'(cur_ch), 64'(ch));
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_period"}, 64'(|period_flat), 64'(0));
    check_val({tag, "_valid"}, 64'(valid), 64'(0));
    check_val({tag, "_stall"}, 64'(stall), 64'(0));
    check_val({tag, "_cur_ch"}, 64'(cur_ch), 64'(0));
    check_val({tag, "_sweep"}, 64'(sweep_done), 64'(0));
  endtask

  initial begin
    bit last;
    bit seen;
    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("rst");
    rst_n = 1'b1;

    // Steady signals on every channel.
    push(0, 3, 1'b1); push(1, 4, 1'b1); push(2, 4, 1'b1); push(3, 4, 1'b1);
    enable = 1'b1;
    drain("steady");

    // ch2 held low: two passes, stall each time.
    enable = 1'b0;
    repeat (5) @(negedge clk);
    per[2] = 0;
    repeat (5) @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      push(0, 3, 1'b1); push(1, 4, 1'b1); push(2, 0, 1'b0); push(3, 4, 1'b1);
    end
    enable = 1'b1;
    drain("stall");

    // ch2 recovers with a 10-cycle period.
    enable = 1'b0;
    repeat (5) @(negedge clk);
    per[2] = 10; hi[2] = 5;
    repeat (5) @(negedge clk);
    push(0, 3, 1'b1); push(1, 4, 1'b1); push(2, 10, 1'b1); push(3, 4, 1'b1);
    enable = 1'b1;
    drain("recover");

    // Abort in the middle of a ch1 measurement.
    enable = 1'b0;
    repeat (5) @(negedge clk);
    per[1] = 30; hi[1] = 15;
    repeat (5) @(negedge clk);
    push(0, 3, 1'b1);
    enable = 1'b1;
    wait_ch(1);
    last = encoder[1];
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      #1;
      seen = encoder[1] && !last;
      last = encoder[1];
    end
    check_val("pin1_rise_seen", 64'(seen), 64'(1));
    repeat (6) @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check_val("abort_cur_ch", 64'(cur_ch), 64'(1));
    check_val("abort_period1", 64'(period_flat[1*WIDTH +: WIDTH]), 64'(exp_period[1]));
    check_val("abort_valid1", 64'(valid[1]), 64'(exp_valid[1]));
    check_val("abort_stall1", 64'(stall[1]), 64'(exp_stall[1]));
    check_val("abort_no_store", 64'(q.size()), 64'(0));
    push(1, 30, 1'b1); push(2, 10, 1'b1); push(3, 4, 1'b1);
    enable = 1'b1;
    drain("resume");

    // Period equal to TIMEOUT is accepted; one cycle longer stalls in MEASURE.
    enable = 1'b0;
    repeat (5) @(negedge clk);
    per[0] = TIMEOUT;     hi[0] = 25;
    per[1] = TIMEOUT + 1; hi[1] = 25;
    repeat (5) @(negedge clk);
    push(0, TIMEOUT, 1'b1); push(1, 0, 1'b0); push(2, 10, 1'b1); push(3, 4, 1'b1);
    enable = 1'b1;
    drain("boundary");

    // Reset asserted while ch1 is being measured.
    push(0, TIMEOUT, 1'b1);
    wait_ch(1);
    check_val("pre_rst_queue", 64'(q.size()), 64'(0));
    repeat (20) @(negedge clk);
    rst_n  = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    check_reset_state("mid_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
